// File: rtl/debug_rx_pkg.sv
// Shared types and helpers for the parametrised debug serial receiver.
package debug_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } rx_state_e;

    localparam int DEFAULT_DATA_WIDTH = 40;

    // Bit count must be able to reach DATA_WIDTH once the final payload bit lands.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/debug_rx_out_reg.sv
// One-entry output holding register: valid/ready handshake, word load and overrun pulse.
module debug_rx_out_reg
    import debug_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  debug_clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_perr,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  out_valid,
    output logic                  parity_err,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  overrun_q, overrun_d;

    // A completing frame may replace the held word only if the slot is empty or being drained this edge.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        if (load) begin
            if (valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = load_data;
                perr_d  = load_perr;
                valid_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    assign data       = data_q;
    assign out_valid  = valid_q;
    assign parity_err = perr_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/debug_serial_receiver.sv
// Start-qualified serial deserialiser for the debug link with selectable width, bit order and parity.
module debug_serial_receiver
    import debug_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  debug_clk,
    input  logic                  reset,
    input  logic                  data_start,
    input  logic                  sin,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int                CW       = count_width(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST_IDX = CW'(DATA_WIDTH - 1);
    localparam logic              ODD_BIT  = (PARITY_ODD != 0);

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic                  load;
    logic                  load_perr;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[DATA_WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // The word handed to the output register is shift_d, so the bit sampled on the completing edge is included.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        load      = 1'b0;
        load_perr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_start) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                end
            end
            ST_SHIFT: begin
                shift_d = shifted;
                count_d = count_q + CW'(1);
                if (count_q == LAST_IDX) begin
                    if (PARITY_EN != 0) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_IDLE;
                        load    = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                state_d   = ST_IDLE;
                load      = 1'b1;
                load_perr = ((^shift_q) ^ sin) != ODD_BIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    debug_rx_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .debug_clk (debug_clk),
        .reset     (reset),
        .load      (load),
        .load_data (shift_d),
        .load_perr (load_perr),
        .out_ready (out_ready),
        .data      (data),
        .out_valid (out_valid),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

endmodule

// File: doc/debug_serial_receiver.md
Name: debug_serial_receiver

Overview:
- Parametrised successor to the fixed 40-bit debug serial receiver.
- Deserialises a start-qualified serial frame from the debug link into a DATA_WIDTH word.
- Frame length, bit order and parity are selectable.
- Delivers each word on a valid/ready handshake with overrun detection, so the debug decoder may stall without silently losing words.

Parameters:
- DATA_WIDTH, 40, payload bits per frame (2..64).
- MSB_FIRST, 0, 0 = first serial bit lands in data[0]; 1 = first serial bit lands in data[DATA_WIDTH-1].
- PARITY_EN, 0, 1 = one parity bit follows the payload.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd (payload XOR parity bit must equal PARITY_ODD).

Ports:
- debug_clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_start  input  1  frame start qualifier, sampled in IDLE.
- sin  input  1  serial data, sampled on posedge.
- data  output  DATA_WIDTH  received word; held stable while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- parity_err  output  1  qualifies data; 0 when PARITY_EN=0.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- busy  output  1  high in SHIFT/PARITY.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, count=0, shift register=0, data=0, out_valid=0, parity_err=0, overrun=0, busy=0.
- FSM states: IDLE, SHIFT, PARITY.
  - IDLE: data_start=1 at posedge moves to SHIFT with count=0. sin on that edge is not captured.
  - SHIFT: every posedge captures sin and increments count (width clog2(DATA_WIDTH+1)).
    - LSB order: shift <= {sin, shift[W-1:1]}.
    - MSB order: shift <= {shift[W-2:0], sin}.
    - On the edge capturing bit DATA_WIDTH-1: go to PARITY if PARITY_EN=1, else complete the frame and return to IDLE.
  - PARITY: capture sin as the parity bit, complete the frame, return to IDLE.
- No idle gap is required between frames. data_start may be high on the edge after completion, and a new frame starts.
- data_start in SHIFT/PARITY is ignored.
- Completion is registered on the completing edge: the assembled word (including the bit sampled on that edge) appears on data, and out_valid=1, after that same edge.
  - Latency from data_start edge to out_valid: DATA_WIDTH+PARITY_EN cycles.
- parity_err = (XOR(payload) ^ parity_bit) != PARITY_ODD. It is registered with data.
- Handshake:
  - out_valid stays high and data/parity_err stay frozen until a cycle with out_ready=1.
  - out_valid falls after the accepting edge unless a new frame completes on that same edge.
  - Completion on an accepting edge: load the new word, keep out_valid=1, no overrun.
  - Completion while out_valid=1 and out_ready=0: new word discarded, old word kept, overrun=1 for exactly one cycle.
  - Capture is never stalled.
- busy = (state != IDLE).
- Reset mid-frame aborts the frame immediately. No out_valid for the partial word.

Decomposition:
- Shared package debug_rx_pkg:
  - state enum (IDLE/SHIFT/PARITY);
  - localparam default DATA_WIDTH=40;
  - function computing count width.
- Natural sub-module debug_rx_out_reg: one-entry output holding register with valid/ready, load and overrun logic. The FSM and shifter stay in the top.

Test Plan:
- DATA_WIDTH=8, LSB, no parity: data_start=1 one cycle, then sin=0,1,0,0,1,0,0,0 -> data=0x12, out_valid high 8 cycles after the start edge, parity_err=0.
- Same stream with MSB_FIRST=1 -> data=0x48.
- PARITY_EN=1, even, payload 0x12:
  - parity bit 0 -> parity_err=0;
  - parity bit 1 -> parity_err=1.
  - out_valid arrives 9 cycles after start.
- out_ready=0 held, two back-to-back frames 0x12 then 0xFF -> data stays 0x12, overrun pulses once on the second completion edge. Then out_ready=1 -> out_valid drops next edge.
- out_ready pulsed on the exact completion edge of frame 2 -> data=frame 2, out_valid continuous, overrun=0.
- DATA_WIDTH=40, reset asserted after bit 20 -> all outputs 0 immediately. Next full frame with alternating 1,0,... -> data=0x5555555555.
